// File: rtl/cv32e40px_core_v_xif_pkg.sv
// XIF shared types: the offload tracker entry and its default depth.
package cv32e40px_core_v_xif_pkg;

  localparam int unsigned XIF_TRACK_DEPTH = 4;
  // Ids are held zero-extended to this width so the entry type does not depend on X_ID_WIDTH.
  localparam int unsigned XIF_ID_MAX_W = 16;

  typedef struct packed {
    logic                    valid;
    logic                    committed;
    logic [XIF_ID_MAX_W-1:0] id;
    logic [4:0]              rd;
    logic                    wb;
  } xif_track_entry_t;

endpackage

// File: rtl/cv32e40px_ff_one.sv
// Leading-one finder: index of the lowest set bit, plus an all-zero flag.
module cv32e40px_ff_one #(
  parameter int unsigned LEN = 4
) (
  input  logic [LEN-1:0]                            in_i,
  output logic [((LEN > 1) ? $clog2(LEN) : 1)-1:0] first_one_o,
  output logic                                      no_ones_o
);

  localparam int unsigned IW = (LEN > 1) ? $clog2(LEN) : 1;

  always_comb begin
    first_one_o = '0;
    // Scan high to low so the lowest set bit wins.
    for (int i = int'(LEN) - 1; i >= 0; i--) begin
      if (in_i[i]) first_one_o = IW'(i);
    end
    no_ones_o = ~|in_i;
  end

endmodule

// File: rtl/cv32e40px_xif_offload_tracker.sv
// Tracks in-flight XIF offloads from issue through commit to result, and flags protocol misuse.
module cv32e40px_xif_offload_tracker
  import cv32e40px_core_v_xif_pkg::*;
#(
  parameter int unsigned X_ID_WIDTH = 4,
  parameter int unsigned DEPTH      = XIF_TRACK_DEPTH
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       issue_valid_i,
  input  logic                       issue_ready_i,
  input  logic                       issue_accept_i,
  input  logic                       issue_writeback_i,
  input  logic [X_ID_WIDTH-1:0]      issue_id_i,
  input  logic [4:0]                 issue_rd_i,
  input  logic                       commit_valid_i,
  input  logic [X_ID_WIDTH-1:0]      commit_id_i,
  input  logic                       commit_kill_i,
  input  logic                       result_valid_i,
  input  logic [X_ID_WIDTH-1:0]      result_id_i,
  output logic                       result_ready_o,
  output logic [4:0]                 result_rd_o,
  output logic                       result_we_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] outstanding_o,
  output logic [31:0]                rd_busy_o,
  output logic                       protocol_err_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = $clog2(DEPTH);

  // Handshakes: a transfer happens on a rising edge where valid (and ready, for issue/result)
  // are both high; valid never waits on ready, and result_ready is a pure function of the
  // current result request and registered entry state.
  xif_track_entry_t entry_q [DEPTH];
  xif_track_entry_t entry_d [DEPTH];

  logic [DEPTH-1:0] valid_vec, dup_hit, cmt_hit, res_id_hit, res_hit, kill_vec, res_free;
  logic [IW-1:0]    free_idx;
  logic             no_free, alloc_req, alloc, err_set, err_q;
  logic [CW-1:0]    count;

  cv32e40px_ff_one #(.LEN(DEPTH)) u_free_sel (
    .in_i        (~valid_vec),
    .first_one_o (free_idx),
    .no_ones_o   (no_free)
  );

  // One comparator per entry per port; ids among live entries are unique, so hits are one-hot.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i]  = entry_q[i].valid;
      dup_hit[i]    = entry_q[i].valid && (entry_q[i].id == XIF_ID_MAX_W'(issue_id_i));
      cmt_hit[i]    = entry_q[i].valid && (entry_q[i].id == XIF_ID_MAX_W'(commit_id_i));
      res_id_hit[i] = entry_q[i].valid && (entry_q[i].id == XIF_ID_MAX_W'(result_id_i));
      res_hit[i]    = res_id_hit[i] && entry_q[i].committed;
    end
  end

  always_comb begin
    result_ready_o = result_valid_i && (|res_hit);
    result_rd_o    = '0;
    result_we_o    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (result_ready_o && res_hit[i]) begin
        result_rd_o = result_rd_o | entry_q[i].rd;
        result_we_o = result_we_o | entry_q[i].wb;
      end
    end
  end

  assign alloc_req = issue_valid_i && issue_ready_i && issue_accept_i;
  assign alloc     = alloc_req && !no_free && !(|dup_hit);
  assign kill_vec  = (commit_valid_i && commit_kill_i) ? cmt_hit : '0;
  assign res_free  = result_ready_o ? res_hit : '0;
  assign err_set   = (alloc_req && (no_free || (|dup_hit)))
                   || (commit_valid_i && !(|cmt_hit))
                   || (result_valid_i && !(|res_id_hit))
                   || (|(kill_vec & res_free));

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_d[i] = entry_q[i];
      if (commit_valid_i && !commit_kill_i && cmt_hit[i]) entry_d[i].committed = 1'b1;
      if (kill_vec[i] || res_free[i]) entry_d[i] = '0;
      // The chosen slot is free in registered state, so it never collides with a hit above.
      if (alloc && (free_idx == IW'(i))) begin
        entry_d[i].valid     = 1'b1;
        entry_d[i].committed = 1'b0;
        entry_d[i].id        = XIF_ID_MAX_W'(issue_id_i);
        entry_d[i].rd        = issue_rd_i;
        entry_d[i].wb        = issue_writeback_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
      err_q <= 1'b0;
    end else begin
      entry_q <= entry_d;
      err_q   <= err_q | err_set;
    end
  end

  always_comb begin
    count     = '0;
    rd_busy_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count = count + CW'(entry_q[i].valid);
      if (entry_q[i].valid && entry_q[i].wb) rd_busy_o[entry_q[i].rd] = 1'b1;
    end
    rd_busy_o[0] = 1'b0;
  end

  assign outstanding_o  = count;
  assign full_o         = no_free;
  assign empty_o        = (count == '0);
  assign protocol_err_o = err_q;

endmodule

// File: doc/cv32e40px_xif_offload_tracker.md
CV32E40PX_XIF_OFFLOAD_TRACKER -- requirements
Module: cv32e40px_xif_offload_tracker

Interface
REQ-001 SHALL have parameter X_ID_WIDTH, default 4: width of the offload id.
REQ-002 SHALL have parameter DEPTH, default 4: number of tracked in-flight offloads; legal range 2..16.
REQ-003 SHALL have port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have ports issue_valid_i / issue_ready_i / issue_accept_i / issue_writeback_i, input, 1 each: the observed issue handshake and response.
REQ-006 SHALL have ports issue_id_i, input, X_ID_WIDTH, and issue_rd_i, input, 5: the id and destination register of the issued instruction.
REQ-007 SHALL have ports commit_valid_i, input, 1; commit_id_i, input, X_ID_WIDTH; commit_kill_i, input, 1.
REQ-008 SHALL have ports result_valid_i, input, 1; result_id_i, input, X_ID_WIDTH; result_ready_o, output, 1.
REQ-009 SHALL have ports result_rd_o, output, 5, and result_we_o, output, 1: rd and writeback flag of the matched entry.
REQ-010 SHALL have ports full_o and empty_o, output, 1 each; outstanding_o, output, $clog2(DEPTH+1): live entry count.
REQ-011 SHALL have port rd_busy_o, output, 32: bit r set iff a live entry has writeback=1 and rd=r; bit 0 is always 0.
REQ-012 SHALL have port protocol_err_o, output, 1: sticky protocol-violation flag.

Function
REQ-013 Entry fields: valid, committed, id, rd, wb. An allocation occurs when issue_valid_i & issue_ready_i & issue_accept_i & !full_o.
REQ-014 Allocation SHALL fill the lowest-index free entry; the entry is visible in the outputs the cycle after the handshake.
REQ-015 full_o SHALL be asserted when all DEPTH entries are valid; an allocation attempted while full_o=1 SHALL be dropped and set protocol_err_o, even if a free occurs in the same cycle.
REQ-016 A commit SHALL match the valid entry with equal id: kill=0 sets committed; kill=1 frees the entry in the next cycle.
REQ-017 result_ready_o SHALL be combinationally 1 iff result_valid_i and a valid, committed entry has id == result_id_i; otherwise 0.
REQ-018 When result_ready_o=1, result_rd_o and result_we_o SHALL carry the matched entry's rd and wb; when result_ready_o=0 they SHALL be 0.
REQ-019 A result handshake (result_valid_i & result_ready_o) SHALL free the matched entry on the next edge.
REQ-020 A result for a valid but uncommitted id SHALL stall (ready=0) with no error.
REQ-021 A result or commit whose id matches no valid entry SHALL set protocol_err_o.
REQ-022 An allocation whose id equals that of a live entry SHALL be dropped and set protocol_err_o.
REQ-023 Allocation, commit and result on different entries in the same cycle SHALL all take effect.
REQ-024 A commit-kill and a result handshake on the same id in the same cycle SHALL free the entry once and set protocol_err_o.
REQ-025 outstanding_o SHALL equal the number of valid entries; next count = count + alloc - frees, where frees is 0..2.
REQ-026 empty_o = (outstanding_o == 0); rd_busy_o, full_o, empty_o and outstanding_o SHALL be derived from registered state only.

Reset
REQ-027 While rst_i=1 at a clock edge, all entries SHALL be invalidated, and full_o=0, empty_o=1, outstanding_o=0, rd_busy_o=0 and protocol_err_o=0.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight entries; no handshake input is honoured in that cycle.
REQ-029 protocol_err_o SHALL clear only on reset.

Structure
REQ-030 The entry struct typedef and the DEPTH default constant SHALL live in cv32e40px_core_v_xif_pkg, next to the existing XIF types.
REQ-031 Free-slot selection SHALL use one sub-module, cv32e40px_ff_one (leading-one finder over the inverted valid vector).
REQ-032 The id-match logic SHALL be DEPTH parallel comparators, one per port (commit, result, issue-duplicate).

Verification
REQ-033 Issue id=3, rd=5, wb=1 -> next cycle outstanding_o=1 and rd_busy_o[5]=1; commit id=3 kill=0, then result id=3 -> ready=1, result_rd_o=5; one cycle later empty_o=1.
REQ-034 Four issues, ids 0..3, with DEPTH=4 -> full_o=1; a fifth issue, id 7 -> dropped, protocol_err_o=1, outstanding_o stays 4.
REQ-035 Issue id=2, then result id=2 before commit -> ready=0 for 3 cycles; commit id=2 -> ready=1 in the same cycle as the commit takes effect.
REQ-036 Issue ids 1 and 2, then commit id=1 kill=1 in the same cycle as the id=2 result (already committed) -> both entries freed, outstanding_o=0, no error.
REQ-037 Full state, then rst_i high for 1 cycle -> outstanding_o=0, empty_o=1, rd_busy_o=0, protocol_err_o=0.
REQ-038 Issue id=4, then issue id=4 again -> second issue dropped, protocol_err_o=1, outstanding_o=1.
